// File: rtl/cml_rx_pkg.sv
// Shared types and helpers for the CameraLink word-alignment controller.
package cml_rx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCheck  = 3'd1,
    StSlip   = 3'd2,
    StWait   = 3'd3,
    StLocked = 3'd4,
    StError  = 3'd5
  } align_state_e;

  localparam logic [6:0] CLK_PATTERN_DEF = 7'b1100011;

  // Bits needed to hold a counter that reaches max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cml_align_fsm.sv
// Single-channel alignment FSM: bitslips until the clock-lane word matches,
// then tracks lock and flags channels that exhaust their slip budget.
module cml_align_fsm
  import cml_rx_pkg::*;
#(
  parameter logic [6:0]  CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int unsigned SLIP_WAIT   = 4,
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned LOSS_COUNT  = 4,
  parameter int unsigned MAX_SLIPS   = 14
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [6:0] i_clk_word,
  output logic       o_bitslip,
  output logic       o_locked,
  output logic       o_align_err,
  output logic [3:0] o_slip_cnt
);

  localparam int unsigned MatchW = cnt_w(LOCK_COUNT);
  localparam int unsigned WaitW  = cnt_w(SLIP_WAIT);
  localparam int unsigned MissW  = cnt_w(LOSS_COUNT);
  localparam int unsigned SlipW  = cnt_w(MAX_SLIPS);

  align_state_e      state_d, state_q;
  logic [MatchW-1:0] match_d, match_q;
  logic [WaitW-1:0]  wait_d, wait_q;
  logic [MissW-1:0]  miss_d, miss_q;
  logic [SlipW-1:0]  slip_d, slip_q;
  logic              bitslip_d, bitslip_q;
  logic              locked_d, locked_q;
  logic              err_d, err_q;
  logic              word_ok;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    wait_d    = wait_q;
    miss_d    = miss_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    locked_d  = locked_q;
    err_d     = err_q;
    word_ok   = (i_clk_word == CLK_PATTERN);
    if (!i_enable) begin
      state_d  = StIdle;
      match_d  = '0;
      wait_d   = '0;
      miss_d   = '0;
      slip_d   = '0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StCheck;
          match_d = '0;
          slip_d  = '0;
        end
        StCheck: begin
          if (word_ok) begin
            if (match_q == MatchW'(LOCK_COUNT - 1)) begin
              state_d  = StLocked;
              locked_d = 1'b1;
              miss_d   = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else if (slip_q == SlipW'(MAX_SLIPS)) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            // Pulse is registered, so it is high exactly while in StSlip.
            state_d   = StSlip;
            bitslip_d = 1'b1;
            slip_d    = slip_q + 1'b1;
          end
        end
        StSlip: begin
          state_d = StWait;
          wait_d  = '0;
        end
        StWait: begin
          if (wait_q == WaitW'(SLIP_WAIT - 1)) begin
            state_d = StCheck;
            match_d = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StLocked: begin
          if (word_ok) begin
            miss_d = '0;
          end else if (miss_q == MissW'(LOSS_COUNT - 1)) begin
            state_d  = StCheck;
            locked_d = 1'b0;
            slip_d   = '0;
            match_d  = '0;
            miss_d   = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        StError: err_d = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      match_q   <= '0;
      wait_q    <= '0;
      miss_q    <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      wait_q    <= wait_d;
      miss_q    <= miss_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign o_bitslip   = bitslip_q;
  assign o_locked    = locked_q;
  assign o_align_err = err_q;
  assign o_slip_cnt  = 4'(slip_q);

endmodule

// File: rtl/cml_rx_align_ctrl.sv
// CameraLink word-alignment controller: one independent alignment FSM per
// channel plus a registered all-channels-locked flag.
module cml_rx_align_ctrl
  import cml_rx_pkg::*;
#(
  parameter int unsigned CAMERALINK_MODE = 2,
  parameter logic [6:0]  CLK_PATTERN     = CLK_PATTERN_DEF,
  parameter int unsigned SLIP_WAIT       = 4,
  parameter int unsigned LOCK_COUNT      = 16,
  parameter int unsigned LOSS_COUNT      = 4,
  parameter int unsigned MAX_SLIPS       = 14
) (
  input  logic                           pixel_clk,
  input  logic                           reset,
  input  logic                           i_enable,
  input  logic [CAMERALINK_MODE*7-1:0]   i_clk_word,
  output logic [CAMERALINK_MODE-1:0]     o_bitslip,
  output logic [CAMERALINK_MODE-1:0]     o_locked,
  output logic                           o_all_locked,
  output logic [CAMERALINK_MODE-1:0]     o_align_err,
  output logic [CAMERALINK_MODE*4-1:0]   o_slip_cnt
);

  for (genvar c = 0; c < CAMERALINK_MODE; c++) begin : g_ch
    cml_align_fsm #(
      .CLK_PATTERN (CLK_PATTERN),
      .SLIP_WAIT   (SLIP_WAIT),
      .LOCK_COUNT  (LOCK_COUNT),
      .LOSS_COUNT  (LOSS_COUNT),
      .MAX_SLIPS   (MAX_SLIPS)
    ) u_fsm (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .i_enable    (i_enable),
      .i_clk_word  (i_clk_word[7*c +: 7]),
      .o_bitslip   (o_bitslip[c]),
      .o_locked    (o_locked[c]),
      .o_align_err (o_align_err[c]),
      .o_slip_cnt  (o_slip_cnt[4*c +: 4])
    );
  end

  logic all_locked_d, all_locked_q;

  // Gated by i_enable so the flag clears on the same edge as the per-channel locks.
  always_comb begin
    all_locked_d = i_enable & (&o_locked);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= all_locked_d;
    end
  end

  assign o_all_locked = all_locked_q;

endmodule

// File: tb/tb_cml_rx_align_ctrl.sv
// Directed bench for cml_rx_align_ctrl with three channels and a rotating
// clock-lane word model that responds to bitslip pulses.
module tb_cml_rx_align_ctrl;

  localparam int unsigned M = 3;
  localparam logic [6:0] PAT = 7'b1100011;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_enable;
  logic [M*7-1:0] clk_word;
  logic [M-1:0]   o_bitslip, o_locked, o_align_err;
  logic           o_all_locked;
  logic [M*4-1:0] o_slip_cnt;

  int checks = 0;
  int errors = 0;

  int unsigned rot_init  [M] = '{default: 0};
  int unsigned base      [M] = '{default: 0};
  int unsigned viol_base [M] = '{default: 0};
  int unsigned pulse_cnt [M] = '{default: 0};
  int unsigned gap_viol  [M] = '{default: 0};
  int unsigned last_cyc  [M] = '{default: 0};
  int unsigned cyc = 0;
  bit          corrupt   [M];
  bit          stuck     [M];

  always #5 clk = ~clk;

  cml_rx_align_ctrl #(
    .CAMERALINK_MODE (M)
  ) dut (
    .pixel_clk    (clk),
    .reset        (rst),
    .i_enable     (i_enable),
    .i_clk_word   (clk_word),
    .o_bitslip    (o_bitslip),
    .o_locked     (o_locked),
    .o_all_locked (o_all_locked),
    .o_align_err  (o_align_err),
    .o_slip_cnt   (o_slip_cnt)
  );

  function automatic logic [6:0] rotl(input logic [6:0] p, input int unsigned r);
    logic [13:0] t;
    t = {p, p} << r;
    return t[13:7];
  endfunction

  // Each bitslip pulse moves the channel one rotation closer to alignment.
  always_comb begin
    clk_word = '0;
    for (int c = 0; c < M; c++) begin
      if (stuck[c]) begin
        clk_word[7*c +: 7] = 7'h00;
      end else begin
        clk_word[7*c +: 7] = rotl(PAT, (rot_init[c] + 7000 - (pulse_cnt[c] - base[c])) % 7)
                             ^ (corrupt[c] ? 7'h7F : 7'h00);
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < M; c++) begin
      if (o_bitslip[c]) begin
        pulse_cnt[c] <= pulse_cnt[c] + 1;
        if (pulse_cnt[c] != 0 && (cyc - last_cyc[c]) < 6) gap_viol[c] <= gap_viol[c] + 1;
        last_cyc[c] <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart(input int unsigned r0, input int unsigned r1, input int unsigned r2);
    i_enable = 1'b0;
    tick(2);
    rot_init[0] = r0;
    rot_init[1] = r1;
    rot_init[2] = r2;
    for (int c = 0; c < M; c++) begin
      base[c]      = pulse_cnt[c];
      viol_base[c] = gap_viol[c];
      corrupt[c]   = 1'b0;
      stuck[c]     = 1'b0;
    end
    i_enable = 1'b1;
  endtask

  function automatic logic [31:0] pulses(input int c);
    return pulse_cnt[c] - base[c];
  endfunction

  function automatic logic [31:0] viols();
    return (gap_viol[0] - viol_base[0]) + (gap_viol[1] - viol_base[1])
         + (gap_viol[2] - viol_base[2]);
  endfunction

  initial begin
    rst      = 1'b1;
    i_enable = 1'b0;
    tick(3);
    check_eq("rst_locked", o_locked, 0);
    check_eq("rst_all", o_all_locked, 0);
    check_eq("rst_slip", o_bitslip, 0);
    check_eq("rst_err", o_align_err, 0);
    check_eq("rst_cnt", o_slip_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Already aligned: lock after edge 16, all-locked after edge 17.
    restart(0, 0, 0);
    for (int e = 0; e <= 17; e++) begin
      tick(1);
      if (e == 15) check_eq("al_lock15", o_locked, 3'b000);
      if (e == 16) check_eq("al_lock16", o_locked, 3'b111);
      if (e == 16) check_eq("al_all16", o_all_locked, 0);
      if (e == 17) check_eq("al_all17", o_all_locked, 1);
    end
    check_eq("al_pulses", pulses(0) + pulses(1) + pulses(2), 0);
    check_eq("al_cnt", o_slip_cnt, 12'h000);

    // Misaligned by 3 everywhere: each slip costs 6 edges, lock at edge 34.
    restart(3, 3, 3);
    for (int e = 0; e <= 35; e++) begin
      tick(1);
      if (e == 33) check_eq("m3_lock33", o_locked, 3'b000);
      if (e == 34) check_eq("m3_lock34", o_locked, 3'b111);
    end
    check_eq("m3_pulses0", pulses(0), 3);
    check_eq("m3_pulses2", pulses(2), 3);
    check_eq("m3_cnt", o_slip_cnt, 12'h333);
    check_eq("m3_gap", viols(), 0);

    // Independent channels: ch0 aligned, ch1 five slips, ch2 two slips.
    restart(0, 5, 2);
    for (int e = 0; e <= 47; e++) begin
      tick(1);
      if (e == 16) check_eq("ind_lock16", o_locked, 3'b001);
      if (e == 28) check_eq("ind_lock28", o_locked, 3'b101);
      if (e == 45) check_eq("ind_lock45", o_locked, 3'b101);
      if (e == 46) check_eq("ind_lock46", o_locked, 3'b111);
      if (e == 46) check_eq("ind_all46", o_all_locked, 0);
      if (e == 47) check_eq("ind_all47", o_all_locked, 1);
    end
    check_eq("ind_cnt", o_slip_cnt, 12'h250);
    check_eq("ind_pulses1", pulses(1), 5);
    check_eq("ind_gap", viols(), 0);

    // Never aligns: 14 slips, error after edge 85, no further pulses.
    restart(0, 0, 0);
    stuck[0] = 1'b1;
    stuck[1] = 1'b1;
    stuck[2] = 1'b1;
    for (int e = 0; e <= 100; e++) begin
      tick(1);
      if (e == 84) check_eq("ne_err84", o_align_err, 3'b000);
      if (e == 85) check_eq("ne_err85", o_align_err, 3'b111);
    end
    check_eq("ne_err", o_align_err, 3'b111);
    check_eq("ne_pulses0", pulses(0), 14);
    check_eq("ne_pulses1", pulses(1), 14);
    check_eq("ne_cnt", o_slip_cnt, 12'hEEE);
    check_eq("ne_locked", o_locked, 3'b000);
    check_eq("ne_gap", viols(), 0);
    i_enable = 1'b0;
    tick(1);
    check_eq("ne_err_clr", o_align_err, 3'b000);
    check_eq("ne_cnt_clr", o_slip_cnt, 12'h000);
    restart(0, 0, 0);
    tick(17);
    check_eq("ne_relock", o_locked, 3'b111);

    // Loss of lock on ch1: three misses then a match keep lock; four drop it.
    tick(1);
    check_eq("ll_all0", o_all_locked, 1);
    corrupt[1] = 1'b1;
    tick(3);
    corrupt[1] = 1'b0;
    check_eq("ll_hold3", o_locked, 3'b111);
    tick(1);
    check_eq("ll_hold_match", o_locked, 3'b111);
    corrupt[1] = 1'b1;
    tick(3);
    check_eq("ll_miss3", o_locked, 3'b111);
    tick(1);
    corrupt[1] = 1'b0;
    check_eq("ll_drop", o_locked, 3'b101);
    check_eq("ll_all_lag", o_all_locked, 1);
    tick(1);
    check_eq("ll_all_drop", o_all_locked, 0);
    tick(14);
    check_eq("ll_relock15", o_locked, 3'b101);
    tick(1);
    check_eq("ll_relock16", o_locked, 3'b111);
    check_eq("ll_cnt1", o_slip_cnt[7:4], 0);
    check_eq("ll_pulses1", pulses(1), 0);

    // Reset during a bitslip pulse clears outputs without waiting for a clock.
    restart(3, 0, 0);
    tick(2);
    check_eq("rs_pulse", o_bitslip, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rs_slip", o_bitslip, 3'b000);
    check_eq("rs_cnt", o_slip_cnt, 12'h000);
    check_eq("rs_locked", o_locked, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Dropping enable in WAIT returns to IDLE with counters cleared.
    restart(3, 0, 0);
    tick(4);
    check_eq("en_wait_cnt", o_slip_cnt[3:0], 1);
    i_enable = 1'b0;
    tick(1);
    check_eq("en_off_cnt", o_slip_cnt, 12'h000);
    check_eq("en_off_slip", o_bitslip, 3'b000);
    check_eq("en_off_locked", o_locked, 3'b000);
    i_enable = 1'b1;
    tick(2);
    check_eq("en_re_cnt", o_slip_cnt[3:0], 1);
    check_eq("en_re_slip", o_bitslip, 3'b001);
    tick(26);
    check_eq("en_re_lock27", o_locked, 3'b110);
    tick(1);
    check_eq("en_re_lock28", o_locked, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cml_rx_align_ctrl.md
Name: cml_rx_align_ctrl

Overview:
- Word-alignment controller for the CameraLink deserializer: one independent alignment FSM per CameraLink channel.
- Each FSM watches that channel's deserialized 7-bit clock-lane word and issues single-cycle bitslip pulses to the ISERDES until the word equals the CameraLink clock pattern.
- It declares lock per channel, monitors for loss of lock, and flags channels that cannot align.
- Sits between the 1:7 SDR receiver (bitslip input, clock-lane word output) and the bit-allocation decoder, whose output is valid only while o_all_locked is high.

Parameters:
- CAMERALINK_MODE, 2, number of channels (Base=1, Medium=2, Full=3).
- CLK_PATTERN, 7'b1100011, expected clock-lane word when aligned.
- SLIP_WAIT, 4, cycles to wait after a bitslip before comparing (1..15).
- LOCK_COUNT, 16, consecutive matches required to declare lock (2..255).
- LOSS_COUNT, 4, consecutive mismatches while locked that drop lock (1..15).
- MAX_SLIPS, 14, slips attempted without lock before error (1..15).

Ports:
- pixel_clk  in  1  recovered pixel clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  starts/holds alignment; low forces every FSM to IDLE.
- i_clk_word  in  CAMERALINK_MODE*7  deserialized clock-lane word; channel c occupies bits [7c+6:7c].
- o_bitslip  out  CAMERALINK_MODE  one-cycle bitslip pulse per channel to the ISERDES.
- o_locked  out  CAMERALINK_MODE  per-channel lock flag.
- o_all_locked  out  1  registered AND of o_locked.
- o_align_err  out  CAMERALINK_MODE  per-channel alignment failure.
- o_slip_cnt  out  CAMERALINK_MODE*4  per-channel slips in the current attempt (debug).

Behaviour:
- All outputs are registered. Reset value of every output is 0; FSMs reset to IDLE with all counters at 0.
- States: IDLE, CHECK, SLIP, WAIT, LOCKED, ERROR.
- i_enable low has priority in every state: next state IDLE, counters cleared, and all outputs 0 on the following edge.
- IDLE: if i_enable, go to CHECK with match_cnt=0 and slip_cnt=0.
- CHECK: compare the word against CLK_PATTERN each cycle.
  - Match: match_cnt+1. When the LOCK_COUNT-th consecutive match is seen, go to LOCKED.
  - Mismatch: if slip_cnt==MAX_SLIPS, go to ERROR; otherwise go to SLIP.
- SLIP: o_bitslip=1 for exactly this one cycle, slip_cnt+1, then go to WAIT with wait_cnt=0.
- WAIT: no comparisons. After SLIP_WAIT cycles, go to CHECK with match_cnt=0.
  - Consecutive bitslip pulses are therefore always at least SLIP_WAIT+2 cycles apart.
- LOCKED: o_locked=1; a mismatch increments miss_cnt and a match clears it.
  - When miss_cnt reaches LOSS_COUNT, go to CHECK with o_locked=0 on that edge, slip_cnt=0 and match_cnt=0.
  - A match on the same cycle the count would complete cancels the loss.
- ERROR: o_align_err=1, held until i_enable is low. No bitslip pulses are issued in ERROR.
- Latency, already-aligned input: i_enable sampled at edge k gives CHECK at k+1 and o_locked high after edge k+LOCK_COUNT. o_all_locked follows one edge later.
- o_slip_cnt tracks slip_cnt and saturates at 15; it holds its value in LOCKED and ERROR.
- Channels are fully independent. o_all_locked drops one cycle after any channel drops lock.
- Reset asserted mid-slip truncates the bitslip pulse immediately (asynchronous clear).

Decomposition:
- Package cml_rx_pkg holds:
  - the state encoding localparams: IDLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4, ERROR=5;
  - the default CLK_PATTERN constant;
  - counter widths, derived with $clog2 from LOCK_COUNT, SLIP_WAIT, LOSS_COUNT and MAX_SLIPS.
- Sub-module cml_align_fsm is the single-channel FSM.
  - The top generates CAMERALINK_MODE instances, slices i_clk_word, and registers the AND for o_all_locked.

Test Plan:
- Aligned input: word=7'b1100011 constant, i_enable rises at cycle 0 -> o_locked[0] high at cycle 16, o_all_locked at cycle 17, o_bitslip never pulses, o_slip_cnt=0.
- Misaligned by 3: bench model rotates the word one position per bitslip, starting at rotation 3 -> exactly 3 bitslip pulses each ≥6 cycles apart, o_slip_cnt=3, then o_locked.
- Never aligns: word fixed at 7'h00 -> 14 bitslip pulses, then o_align_err=1 and no further pulses. i_enable low -> err clears the next cycle; i_enable high again -> a new attempt starts.
- Loss of lock: after lock, inject 3 mismatches then a match -> stays locked. Inject 4 consecutive mismatches -> o_locked and o_all_locked fall, FSM re-aligns.
- Multi-channel independence (MODE=3): ch0 aligned, ch1 needs 5 slips, ch2 needs 2 slips -> each lock is independent; o_all_locked rises one cycle after the last channel locks.
- Reset and enable mid-operation: assert reset during a bitslip pulse -> o_bitslip=0 immediately and all outputs 0. Drop i_enable in WAIT -> IDLE next edge with counters cleared.
